cordic: RTL and testbench

- Single registered CORDIC micro-rotation stage, rotation mode: one iteration of x/y/z per clock.
- A top-level sequencer instantiates it, supplies the current x, y, z, the arctan constant alpha (from its own LUT) and the 1-based iteration index, and takes y as the sine result.
- No internal LUT; alpha comes from the parent so one table serves folded or unrolled use.

---
 rtl/cordic_pkg.sv | 30 +++
 rtl/cordic_shift.sv | 19 +
 rtl/cordic.sv | 65 ++++++
 tb/tb_cordic.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC sine datapath (Q2.19 signed words).
// Parents index ATAN_LUT with the 1-based iteration number via atan_for_iter().
package cordic_pkg;

    localparam int WORD_LENGTH = 21;
    localparam int FRAC_BITS   = 19;
    localparam int ITER_WIDTH  = 5;
    localparam int LUT_DEPTH   = 20;

    typedef logic signed [WORD_LENGTH-1:0] q2_19_t;

    // Start x with 1/K so the final y needs no gain correction.
    localparam q2_19_t X0 = 21'sh04DBA7;

    // round(atan(2^-k) * 2^19) for k = 0 .. LUT_DEPTH-1
    localparam q2_19_t ATAN_LUT [LUT_DEPTH] = '{
        21'sh06487F, 21'sh03B58D, 21'sh01F5B7, 21'sh00FEAE,
        21'sh007FD5, 21'sh003FFB, 21'sh001FFF, 21'sh001000,
        21'sh000800, 21'sh000400, 21'sh000200, 21'sh000100,
        21'sh000080, 21'sh000040, 21'sh000020, 21'sh000010,
        21'sh000008, 21'sh000004, 21'sh000002, 21'sh000001
    };

    function automatic q2_19_t atan_for_iter(input logic [ITER_WIDTH-1:0] iter);
        int k;
        k = (iter == '0) ? 0 : int'(iter) - 1;
        return (k < LUT_DEPTH) ? ATAN_LUT[k] : '0;
    endfunction

endpackage

// File: rtl/cordic_shift.sv
// Combinational arithmetic right shifter; shifts of WIDTH or more collapse
// to the sign fill so callers never depend on out-of-range shift semantics.
module cordic_shift #(
    parameter int WIDTH     = 21,
    parameter int AMT_WIDTH = 5
) (
    input  logic signed [WIDTH-1:0]     data,
    input  logic        [AMT_WIDTH-1:0] amount,
    output logic signed [WIDTH-1:0]     result
);

    always_comb begin
        result = {WIDTH{data[WIDTH-1]}};
        if (int'(amount) < WIDTH) begin
            result = data >>> amount;
        end
    end

endmodule

// File: rtl/cordic.sv
// One registered rotation-mode CORDIC micro-rotation; the parent supplies
// x/y/z, the arctan constant and the 1-based iteration index each cycle.
module cordic
    import cordic_pkg::*;
#(
    parameter int WORD_LENGTH = cordic_pkg::WORD_LENGTH,
    parameter int ITER_WIDTH  = cordic_pkg::ITER_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [WORD_LENGTH-1:0] x_i,
    input  logic signed [WORD_LENGTH-1:0] y_i,
    input  logic signed [WORD_LENGTH-1:0] z_i,
    input  logic signed [WORD_LENGTH-1:0] alpha_i,
    input  logic        [ITER_WIDTH-1:0]  iteration_i,
    output logic signed [WORD_LENGTH-1:0] next_x_o,
    output logic signed [WORD_LENGTH-1:0] next_y_o,
    output logic signed [WORD_LENGTH-1:0] next_z_o
);

    logic        [ITER_WIDTH-1:0]  shift_amt;
    logic signed [WORD_LENGTH-1:0] x_shifted;
    logic signed [WORD_LENGTH-1:0] y_shifted;
    logic                          z_negative;

    // Iteration 0 is treated like iteration 1 rather than wrapping to a huge shift.
    assign shift_amt  = (iteration_i == '0) ? '0 : iteration_i - 1'b1;
    assign z_negative = z_i[WORD_LENGTH-1];

    cordic_shift #(
        .WIDTH     (WORD_LENGTH),
        .AMT_WIDTH (ITER_WIDTH)
    ) u_shift_x (
        .data   (x_i),
        .amount (shift_amt),
        .result (x_shifted)
    );

    cordic_shift #(
        .WIDTH     (WORD_LENGTH),
        .AMT_WIDTH (ITER_WIDTH)
    ) u_shift_y (
        .data   (y_i),
        .amount (shift_amt),
        .result (y_shifted)
    );

    // Wrapping arithmetic is intentional; no saturation.
    always_ff @(posedge clk) begin
        if (rst) begin
            next_x_o <= '0;
            next_y_o <= '0;
            next_z_o <= '0;
        end else if (z_negative) begin
            next_x_o <= x_i + y_shifted;
            next_y_o <= y_i - x_shifted;
            next_z_o <= z_i + alpha_i;
        end else begin
            next_x_o <= x_i - y_shifted;
            next_y_o <= y_i + x_shifted;
            next_z_o <= z_i - alpha_i;
        end
    end

endmodule

// File: tb/tb_cordic.sv
// Scoreboard bench for the cordic micro-rotation stage: a longint reference
// model pushes expected outputs when stimulus is driven; outputs are popped one cycle later.
module tb_cordic;

    localparam int W  = 21;
    localparam int IW = 5;

    logic                 clk;
    logic                 rst;
    logic signed [W-1:0]  x_i, y_i, z_i, alpha_i;
    logic        [IW-1:0] iteration_i;
    logic signed [W-1:0]  next_x_o, next_y_o, next_z_o;

    typedef struct {
        string        tag;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] z;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests;
    int   n_fail;

    cordic dut (
        .clk         (clk),
        .rst         (rst),
        .x_i         (x_i),
        .y_i         (y_i),
        .z_i         (z_i),
        .alpha_i     (alpha_i),
        .iteration_i (iteration_i),
        .next_x_o    (next_x_o),
        .next_y_o    (next_y_o),
        .next_z_o    (next_z_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%06h expected 0x%06h", tag, obs, exp_v);
        end
    endtask

    function automatic longint sext(input logic [W-1:0] v);
        longint r;
        r = longint'(v);
        if (v[W-1]) r = r - (longint'(1) <<< W);
        return r;
    endfunction

    function automatic longint ashr(input logic [W-1:0] v, input int s);
        if (s >= W) return v[W-1] ? -1 : 0;
        return sext(v) >>> s;
    endfunction

    function automatic exp_t model(input string tag, input logic r,
                                   input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [W-1:0] z, input logic [W-1:0] a,
                                   input int it);
        exp_t   e;
        int     s;
        longint d;
        e.tag = tag;
        if (r) begin
            e.x = '0; e.y = '0; e.z = '0;
            return e;
        end
        s = (it == 0) ? 0 : it - 1;
        d = z[W-1] ? -1 : 1;
        e.x = W'(sext(x) - d * ashr(y, s));
        e.y = W'(sext(y) + d * ashr(x, s));
        e.z = W'(sext(z) - d * sext(a));
        return e;
    endfunction

    task automatic step(input string tag, input logic r,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] z, input logic [W-1:0] a,
                        input int it);
        exp_t e;
        rst         = r;
        x_i         = x;
        y_i         = y;
        z_i         = z;
        alpha_i     = a;
        iteration_i = IW'(it);
        sb_q.push_back(model(tag, r, x, y, z, a, it));
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got nothing expected one entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk({e.tag, ".x"}, next_x_o, e.x);
            chk({e.tag, ".y"}, next_y_o, e.y);
            chk({e.tag, ".z"}, next_z_o, e.z);
        end
    endtask

    task automatic check_const(input string tag, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic [W-1:0] z);
        chk({tag, ".x"}, next_x_o, x);
        chk({tag, ".y"}, next_y_o, y);
        chk({tag, ".z"}, next_z_o, z);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; x_i = '0; y_i = '0; z_i = '0; alpha_i = '0; iteration_i = '0;

        step("rst0", 1'b1, 21'h12345, 21'h0ABCD, 21'h1F000, 21'h00777, 3);
        step("rst1", 1'b1, 21'h1FFFF, 21'h10000, 21'h00001, 21'h0FFFF, 7);
        check_const("rst_abs", 21'h000000, 21'h000000, 21'h000000);

        // directed vectors, with literal expectations cross-checking the model
        step("first_pos", 1'b0, 21'h04DBA7, 21'h0, 21'h0, 21'h0649B6, 1);
        check_const("first_pos_abs", 21'h04DBA7, 21'h04DBA7, 21'h19B64A);
        step("first_neg", 1'b0, 21'h04DBA7, 21'h0, 21'h1F0000, 21'h0649B6, 1);
        check_const("first_neg_abs", 21'h04DBA7, 21'h1B2459, 21'h0549B6);
        step("shifted", 1'b0, 21'h080000, 21'h040000, 21'h010000, 21'h001000, 3);
        check_const("shifted_abs", 21'h070000, 21'h060000, 21'h00F000);
        step("overshift", 1'b0, 21'h100000, 21'h1FFFFF, 21'h1FFFFF, 21'h0, 30);
        check_const("overshift_abs", 21'h0FFFFF, 21'h000000, 21'h1FFFFF);
        step("wrap", 1'b0, 21'h0FFFFF, 21'h0FFFFF, 21'h0, 21'h0, 1);
        check_const("wrap_abs", 21'h000000, 21'h1FFFFE, 21'h000000);
        step("iter0", 1'b0, 21'h080000, 21'h040000, 21'h1C0000, 21'h000100, 0);
        step("shift20", 1'b0, 21'h180000, 21'h07FFFF, 21'h000010, 21'h000020, 21);
        step("shift21", 1'b0, 21'h180000, 21'h07FFFF, 21'h000010, 21'h000020, 22);
        step("neg_round", 1'b0, 21'h1FFFFD, 21'h1FFFF9, 21'h0, 21'h0, 2);

        // reset mid-sequence then resume
        step("mid_rst", 1'b1, 21'h0AAAAA, 21'h155555, 21'h012345, 21'h0649B6, 4);
        step("post_rst", 1'b0, 21'h0AAAAA, 21'h155555, 21'h012345, 21'h0649B6, 4);

        for (int i = 0; i < 60; i++) begin
            step($sformatf("rand%0d", i), 1'b0, W'($urandom), W'($urandom),
                 W'($urandom), W'($urandom), int'($urandom_range(0, 31)));
        end

        // outputs hold while inputs are stable across a clock
        step("hold_a", 1'b0, 21'h033333, 21'h1CCCCC, 21'h1ABCDE, 21'h003210, 5);
        step("hold_b", 1'b0, 21'h033333, 21'h1CCCCC, 21'h1ABCDE, 21'h003210, 5);

        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
